// File: rtl/ram_burst_reader_if.sv
// Valid/ready stream carrying words read out of the RAM.
// The master side is the burst reader; the slave side is the consumer.
interface ram_burst_reader_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/ram_burst_reader.sv
// Read-only burst initiator for an async-read RAM, streaming words on valid/ready.
// Define CHECKSUM_EN to add a running mod-2^DATA_W sum of accepted beats.
module ram_burst_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_data,
    ram_burst_reader_if.master strm,
    output logic              busy,
    output logic              done
`ifdef CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ZERO = '0;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remaining;
    logic              accept;
    logic              drained;
    logic              load;

    // Output slot is free this cycle if empty or being taken right now.
    assign accept  = strm.out_valid & strm.out_ready;
    assign drained = ~strm.out_valid | strm.out_ready;
    assign load    = (state == S_STREAM) & (remaining != CNT_ZERO) & drained;

    assign ram_addr = addr_q;
    assign ram_we   = 1'b0;
    assign busy     = (state == S_STREAM) | (state == S_DONE);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            remaining     <= '0;
            strm.out_data <= '0;
            strm.out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q    <= base_addr;
                        remaining <= len;
                        state     <= (len == CNT_ZERO) ? S_DONE : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (load) begin
                        strm.out_data  <= ram_data;
                        strm.out_valid <= 1'b1;
                        addr_q         <= addr_q + ADDR_ONE;
                        remaining      <= remaining - CNT_ONE;
                    end else if (accept) begin
                        strm.out_valid <= 1'b0;
                    end
                    // Leave only once the final beat has been taken.
                    if ((remaining == CNT_ZERO) && drained) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if ((state == S_IDLE) && start) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + strm.out_data;
        end
    end
`endif

endmodule
